// File: rtl/fp_addsub_arbiter.sv
// Round-robin sharing of one fp_addsub pipeline among NUM_REQ requesters, with a
// latency-matched requester-ID tag pipe and per-requester in-flight limits.
`ifndef FP_ADD_LATENCY
`define FP_ADD_LATENCY 4
`endif

module fp_addsub_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = `FP_ADD_LATENCY,
  parameter int MAX_OUT    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_sub,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fpu_enable,
  output logic [DATA_WIDTH-1:0]         fpu_op0,
  output logic [DATA_WIDTH-1:0]         fpu_op1,
  input  logic [DATA_WIDTH-1:0]         fpu_res,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  localparam int              CNT_W    = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]       last_r;
  logic [CNT_W-1:0]      out_cnt_r [NUM_REQ];
  logic [NUM_REQ-1:0]    elig_s;
  logic                  grant_vld_s;
  logic [ID_W-1:0]       grant_id_s;
  logic [DATA_WIDTH-1:0] sel_op0_s;
  logic [DATA_WIDTH-1:0] sel_op1_s;
  logic                  sel_sub_s;

  logic                  fpu_enable_r;
  logic [DATA_WIDTH-1:0] fpu_op0_r;
  logic [DATA_WIDTH-1:0] fpu_op1_r;
  logic [ID_W-1:0]       issue_id_r;

  logic [LATENCY-1:0]    tag_vld_r;
  logic [ID_W-1:0]       tag_id_r [LATENCY];

  logic                  rsp_valid_r;
  logic [ID_W-1:0]       rsp_id_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Eligibility: pending request with room for another in-flight op; nothing wins during reset.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && req_valid[i] && (out_cnt_r[i] < MAX_CNT)) begin
        elig_s[i] = 1'b1;
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld_s && elig_s[rr_index(last_r, k)]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = rr_index(last_r, k);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // One-hot grant vector.
  always_comb begin
    req_ready = '0;
    if (grant_vld_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Operand select for the winner.
  always_comb begin
    sel_op0_s = req_op0[int'(grant_id_s)*DATA_WIDTH +: DATA_WIDTH];
    sel_op1_s = req_op1[int'(grant_id_s)*DATA_WIDTH +: DATA_WIDTH];
    sel_sub_s = req_sub[grant_id_s];
  end

  // Issue register; subtraction becomes addition by flipping the op1 sign, NaN/Inf included.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r       <= LAST_RST;
      fpu_enable_r <= 1'b0;
      fpu_op0_r    <= '0;
      fpu_op1_r    <= '0;
      issue_id_r   <= '0;
    end else if (grant_vld_s) begin
      last_r       <= grant_id_s;
      fpu_enable_r <= 1'b1;
      fpu_op0_r    <= sel_op0_s;
      fpu_op1_r    <= {sel_op1_s[DATA_WIDTH-1] ^ sel_sub_s, sel_op1_s[DATA_WIDTH-2:0]};
      issue_id_r   <= grant_id_s;
    end else begin
      fpu_enable_r <= 1'b0;
    end
  end

  // Free-running tag pipe aligned with the fp_addsub latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id_r[i] <= '0;
      end
    end else begin
      tag_vld_r[0] <= fpu_enable_r;
      tag_id_r[0]  <= issue_id_r;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
    end
  end

  // Response register: capture fpu_res only when the matching tag arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= '0;
    end else if (tag_vld_r[LATENCY-1]) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= tag_id_r[LATENCY-1];
      rsp_data_r  <= fpu_res;
    end else begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Per-requester outstanding counters: +1 on grant, -1 on its response, hold when both.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant_vld_s && (grant_id_s == ID_W'(i)), rsp_valid_r && (rsp_id_r == ID_W'(i))})
          2'b10:   out_cnt_r[i] <= out_cnt_r[i] + CNT_W'(1);
          2'b01:   out_cnt_r[i] <= out_cnt_r[i] - CNT_W'(1);
          default: out_cnt_r[i] <= out_cnt_r[i];
        endcase
      end
    end
  end

  // Busy whenever any requester has an operation counted.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (out_cnt_r[i] != '0) begin
        busy = 1'b1;
      end else begin
        busy = busy;
      end
    end
  end

  assign fpu_enable = fpu_enable_r;
  assign fpu_op0    = fpu_op0_r;
  assign fpu_op1    = fpu_op1_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_data   = rsp_data_r;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Scoreboard bench for fp_addsub_arbiter with a stand-in fp_addsub delay line.
module tb_fp_addsub_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 4;
  localparam int MO  = 2;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_sub;
  logic [NR*DW-1:0] req_op0;
  logic [NR*DW-1:0] req_op1;
  logic [NR-1:0]    req_ready;
  logic             fpu_enable;
  logic [DW-1:0]    fpu_op0;
  logic [DW-1:0]    fpu_op1;
  logic [DW-1:0]    fpu_res;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [DW-1:0] op0;
    logic [DW-1:0] op1;
  } iss_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [31:0]    cyc;
  } rsp_t;

  iss_t          iss_q[$];
  rsp_t          rsp_q[$];
  iss_t          exp_iss;
  rsp_t          exp_rsp;
  logic [DW-1:0] fpu_pipe [LAT];

  fp_addsub_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .LATENCY(LAT), .MAX_OUT(MO), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_sub(req_sub), .req_op0(req_op0), .req_op1(req_op1),
    .req_ready(req_ready),
    .fpu_enable(fpu_enable), .fpu_op0(fpu_op0), .fpu_op1(fpu_op1), .fpu_res(fpu_res),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in adder: hand-computed sums for the directed IEEE vectors, XOR marker otherwise.
  function automatic logic [DW-1:0] fake_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    else if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    else return a ^ b;
  endfunction

  always @(posedge clk) begin
    fpu_pipe[0] <= fake_add(fpu_op0, fpu_op1);
    for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_res = fpu_pipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Check the grant for this cycle and queue the expected issue/response for it.
  task automatic step(input logic [NR-1:0] exp_rdy, input string nm);
    logic [DW-1:0] o0;
    logic [DW-1:0] o1;
    @(negedge clk);
    chk(nm, 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < NR; i++) begin
      if (exp_rdy[i]) begin
        o0 = req_op0[i*DW +: DW];
        o1 = req_op1[i*DW +: DW] ^ {req_sub[i], 31'h0};
        iss_q.push_back('{op0: o0, op1: o1});
        rsp_q.push_back('{id: IDW'(i), data: fake_add(o0, o1), cyc: 32'(cyc + LAT + 2)});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      idle = (busy == 1'b0) && (rsp_q.size() == 0) && (iss_q.size() == 0);
    end
    chk(nm, 64'(idle), 64'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues or responds.
  initial begin
    forever begin
      @(negedge clk);
      if (fpu_enable) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue: got op0 %0h op1 %0h expected none", fpu_op0, fpu_op1);
        end else begin
          exp_iss = iss_q.pop_front();
          chk("issue_op0", 64'(fpu_op0), 64'(exp_iss.op0));
          chk("issue_op1", 64'(fpu_op1), 64'(exp_iss.op1));
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got id %0d data %0h expected none", rsp_id, rsp_data);
        end else begin
          exp_rsp = rsp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(exp_rsp.id));
          chk("rsp_data", 64'(rsp_data), 64'(exp_rsp.data));
          chk("rsp_latency", 64'(cyc), 64'(exp_rsp.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '1; req_sub = '0; req_op0 = '0; req_op1 = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_fpu_enable", 64'(fpu_enable), 64'd0);
    chk("rst_fpu_op0", 64'(fpu_op0), 64'd0);
    chk("rst_fpu_op1", 64'(fpu_op1), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;

    // Single add on req0, granted in the first cycle out of reset.
    req_op0[0*DW +: DW] = 32'h3F80_0000;
    req_op1[0*DW +: DW] = 32'h4000_0000;
    req_valid = 4'b0001;
    step(4'b0001, "t1_grant");
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_enable", 64'(fpu_enable), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    wait_idle("t1_drain");

    // Subtract on req2, then a sign flip on a negative NaN from req3.
    req_op0[2*DW +: DW] = 32'h4040_0000;
    req_op1[2*DW +: DW] = 32'h3F80_0000;
    req_sub = 4'b0100;
    req_valid = 4'b0100;
    step(4'b0100, "t2_grant");
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t2_sub_op1", 64'(fpu_op1), 64'h0000_0000_BF80_0000);
    @(posedge clk); #1;
    req_op0[3*DW +: DW] = 32'h1234_5678;
    req_op1[3*DW +: DW] = 32'hFFC0_0000;
    req_sub = 4'b1000;
    req_valid = 4'b1000;
    step(4'b1000, "t2_nan_grant");
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t2_nan_op1", 64'(fpu_op1), 64'h0000_0000_7FC0_0000);
    @(posedge clk); #1;
    wait_idle("t2_drain");

    // Fairness: all valid gives 0,1,2,3,0,1,2,3.
    req_sub = 4'b0000;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) begin
        req_op0[i*DW +: DW] = 32'(32'h1000_0000 * (i + 1) + k);
        req_op1[i*DW +: DW] = 32'(32'h0000_0100 * (k + 1));
      end
      step(4'(1) << (k % 4), "t3_grant");
    end
    req_valid = 4'b0000;
    wait_idle("t3_drain");

    // Outstanding limit of 2 on req1; re-grant the cycle after the first response.
    req_valid = 4'b0010;
    for (int j = 0; j < 8; j++) begin
      req_op0[1*DW +: DW] = 32'(32'h2000_0000 + j);
      req_op1[1*DW +: DW] = 32'h0000_00F0;
      step((j < 2 || j == 7) ? 4'b0010 : 4'b0000, "t4_grant");
    end
    req_valid = 4'b0000;
    wait_idle("t4_drain");

    // req3 issues in the very cycle its earlier response pulses.
    req_op0[3*DW +: DW] = 32'h3000_0001;
    req_op1[3*DW +: DW] = 32'h0000_0011;
    req_valid = 4'b1000;
    step(4'b1000, "t5_grant_a");
    req_valid = 4'b0000;
    for (int j = 0; j < 5; j++) step(4'b0000, "t5_idle");
    req_op0[3*DW +: DW] = 32'h3000_0002;
    req_valid = 4'b1000;
    step(4'b1000, "t5_grant_b");
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t5_cnt3", 64'(dut.out_cnt_r[3]), 64'd1);
    chk("t5_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    wait_idle("t5_drain");

    // Reset mid-flight: three ops discarded, then req0 wins over req3.
    for (int i = 0; i < 3; i++) begin
      req_op0[i*DW +: DW] = 32'(32'h4000_0100 + i);
      req_op1[i*DW +: DW] = 32'h0000_0F0F;
    end
    req_valid = 4'b0111;
    step(4'b0001, "t6_grant0");
    step(4'b0010, "t6_grant1");
    step(4'b0100, "t6_grant2");
    req_valid = 4'b0000;
    step(4'b0000, "t6_idle");
    rst = 1'b1;
    rsp_q.delete();
    req_op0[0*DW +: DW] = 32'h5000_0000;
    req_op1[0*DW +: DW] = 32'h0000_0055;
    req_op0[3*DW +: DW] = 32'h5300_0000;
    req_valid = 4'b1001;
    step(4'b0000, "t6_rst_ready");
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rsp_id", 64'(rsp_id), 64'd0);
    chk("t6_rsp_data", 64'(rsp_data), 64'd0);
    chk("t6_fpu_op0", 64'(fpu_op0), 64'd0);
    rst = 1'b0;
    step(4'b0001, "t6_post_grant");
    req_valid = 4'b0000;
    wait_idle("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Shares one `fp_addsub` floating-point add/subtract pipeline among `NUM_REQ` requesters, such as FPU lanes or hardware threads. Each cycle it round-robin arbitrates among valid requests and issues the winner into the pipeline, converting subtraction into addition by flipping the op1 sign. It carries the requester ID alongside the operation through a tag shift register matched to the pipeline latency, and returns each result tagged with its requester. Per-requester outstanding counters bound the number of in-flight operations and give a drain/busy indication.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 32: operand/result width (IEEE single).
- `LATENCY`, `` `FP_ADD_LATENCY ``: cycles from `fpu_enable` high to the result being valid on `fpu_res`.
- `MAX_OUT`, 4: maximum in-flight operations per requester (≥1).
- `ID_W`, $clog2(NUM_REQ): requester ID width.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_sub`  in  NUM_REQ  1 = op0 − op1, 0 = op0 + op1.
- `req_op0`  in  NUM_REQ*DATA_WIDTH  flattened operand 0; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_op1`  in  NUM_REQ*DATA_WIDTH  flattened operand 1, same layout.
- `req_ready`  out  NUM_REQ  one-hot grant; the handshake is `req_valid[i] & req_ready[i]`.
- `fpu_enable`  out  1  issue strobe to `fp_addsub.enable`.
- `fpu_op0`, `fpu_op1`  out  DATA_WIDTH  operands to the pipeline.
- `fpu_res`  in  DATA_WIDTH  pipeline result.
- `rsp_valid`  out  1  one-cycle result pulse; no backpressure.
- `rsp_id`  out  ID_W  requester that owns `rsp_data`.
- `rsp_data`  out  DATA_WIDTH  result.
- `busy`  out  1  at least one operation in flight or registered for issue.

## Operation
- Eligibility: requester i is eligible when `req_valid[i]` is high and `out_cnt[i] < MAX_OUT`.
- Arbitration: `req_ready` is combinational from `req_valid`, the counters and the RR pointer `last`.
  - Search order is last+1, last+2, … modulo NUM_REQ.
  - At most one bit of `req_ready` is high, and only for an eligible requester.
  - `req_ready` never depends on that requester's own stall; no output stall exists.
- RR pointer: `last` updates to the granted index only on a handshake. Reset value is NUM_REQ−1, so requester 0 wins first.
- Issue register (`fpu_*` outputs are registered): on a handshake by requester g at cycle c, during cycle c+1:
  - `fpu_enable` = 1;
  - `fpu_op0` = `req_op0[g]`;
  - `fpu_op1` = {`req_op1[g]`[MSB] ^ `req_sub[g]`, `req_op1[g]`[MSB−1:0]}; the sign flip applies to NaN/Inf/zero too.
- Without a handshake: `fpu_enable` = 0 and the operand registers hold their last value.
- Tag pipeline: a LATENCY-stage shift register of {valid, id} advances every cycle, unconditionally.
  - Stage 0 loads {`fpu_enable`, issued id}.
  - `fp_addsub` runs its internal clock-enable for LATENCY−1 cycles after its last enable, so an in-flight operation always completes and the free-running tag pipe stays aligned.
- Response register: when the last tag stage is valid, the next cycle presents `rsp_valid`=1, `rsp_id`=tag id, `rsp_data`=`fpu_res` captured that cycle. Otherwise `rsp_valid`=0 and `rsp_id`/`rsp_data` hold.
- Counters `out_cnt[i]` (width $clog2(MAX_OUT+1)):
  - +1 on a handshake by i;
  - −1 when `rsp_valid` is high with `rsp_id` = i;
  - unchanged when both happen in the same cycle;
  - they never overflow, because eligibility blocks at MAX_OUT.
- `busy` = any `out_cnt` ≠ 0. An operation is counted from its handshake cycle+1 until the cycle after its `rsp_valid`.
- Reset:
  - `req_ready` = 0 while `rst` is high;
  - `fpu_enable` = 0, `fpu_op0`/`fpu_op1` = 0;
  - all tag valids = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0;
  - `out_cnt` = 0, `last` = NUM_REQ−1.
- Reset mid-operation: in-flight results are discarded and no `rsp_valid` is produced for them. Stale pipeline contents appear on `fpu_res` but are never tagged.

## Timing
- Handshake in cycle c gives `fpu_enable` in c+1, `fpu_res` valid in c+1+LATENCY, and `rsp_valid` in c+2+LATENCY.
- Total request-to-response latency is LATENCY+2 cycles, fixed and independent of load.
- Throughput is one issue per cycle. Back-to-back issues give back-to-back responses in issue order.
- A requester holding `req_valid` receives a grant within NUM_REQ cycles unless it is at MAX_OUT.
- The first grant can occur in the first cycle after `rst` deasserts.

## Test plan
- **Single op:** req0 adds 0x3F800000 + 0x40000000 → `fpu_enable` 1 cycle later; `rsp_valid` LATENCY+2 cycles after the handshake with `rsp_id`=0, `rsp_data`=0x40400000; `busy` then drops.
- **Subtract:** req2 with `req_sub`=1, 0x40400000 − 0x3F800000 → `fpu_op1`=0xBF800000; response `rsp_id`=2, data 0x40000000.
- **Fairness:** all 4 requesters continuously valid → grant order 0,1,2,3,0,… one per cycle; responses carry ids in the same order, one per cycle.
- **Outstanding limit:** MAX_OUT=2, only req1 valid → two handshakes, then `req_ready[1]`=0 until the first `rsp_valid`/id=1; it re-grants the next cycle.
- **Simultaneous grant and retire:** req3 issues in the same cycle its earlier response pulses → `out_cnt[3]` unchanged, no overflow or underflow.
- **Reset mid-flight:** issue 3 ops, assert `rst` for 1 cycle after LATENCY/2 → no `rsp_valid` for those ops; all counters 0, `busy`=0; the next request is granted to req0 and returns correctly.
